// File: rtl/mult_div_seq.sv
// -----------------------------------------------------------------------------
// mult_div_seq -- sequential signed 32x32 multiply / divide unit.
//
// A start in IDLE latches the operand magnitudes and signs. The unit then runs
// 32 shift-add steps (multiply) or 32 restoring shift-subtract steps (divide),
// applies the sign correction in FIX, and pulses done for one cycle. Latency
// from the start edge to done is 33 cycles.
//
// Ports
//   clk       : clock, rising edge
//   reset     : asynchronous reset, active low
//   start     : operation request, sampled only in IDLE
//   op        : 0 = signed multiply, 1 = signed divide
//   A, B      : operands (multiplicand/multiplier or dividend/divisor)
//   busy      : high in every state except IDLE
//   done      : one-cycle pulse, hi/lo valid
//   div_zero  : one-cycle pulse with done for a trapped divide by zero
//   hi, lo    : product[63:32]/[31:0] or remainder/quotient
//
// Configuration macro
//   DIV_ZERO_TRAP_EN : when defined, a divide with B == 0 finishes one cycle
//                      after start with done and div_zero both high and hi/lo
//                      unchanged. When undefined, div_zero is tied low and the
//                      divide runs normally (quotient magnitude all ones,
//                      remainder |A|).
// -----------------------------------------------------------------------------
module mult_div_seq #(
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     op,
    input  logic signed [DATA_W-1:0] A,
    input  logic signed [DATA_W-1:0] B,
    output logic                     busy,
    output logic                     done,
    output logic                     div_zero,
    output logic        [DATA_W-1:0] hi,
    output logic        [DATA_W-1:0] lo
);

    localparam int ACC_W = 2 * DATA_W;
    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MULT = 3'd1,
        DIV  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0]  cnt;
    logic [ACC_W-1:0]  acc;      // mult: {partial product, multiplier}; div: {remainder, quotient}
    logic [DATA_W-1:0] mag_b;    // multiplicand magnitude or divisor magnitude
    logic              sign_a;
    logic              sign_b;
    logic              op_q;

    logic [DATA_W:0]   mul_sum;
    logic [DATA_W:0]   div_shift;
    logic              div_ge;
    logic [DATA_W-1:0] div_sub;

`ifdef DIV_ZERO_TRAP_EN
    logic dz_q;
`endif

    // Magnitude of a two's complement word; the most negative value maps to
    // 2^(DATA_W-1), which is representable as an unsigned magnitude.
    function automatic logic [DATA_W-1:0] abs_w(input logic signed [DATA_W-1:0] v);
        logic [DATA_W-1:0] u;
        u = v;
        return v[DATA_W-1] ? (~u + DATA_W'(1)) : u;
    endfunction

    // Two's complement negation modulo 2^DATA_W.
    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v, input logic en);
        return en ? (~v + DATA_W'(1)) : v;
    endfunction

    // Two's complement negation of the full 64-bit product.
    function automatic logic [ACC_W-1:0] neg_acc(input logic [ACC_W-1:0] v, input logic en);
        return en ? (~v + ACC_W'(1)) : v;
    endfunction

    // -------------------------------------------------------------------------
    // Step arithmetic
    // -------------------------------------------------------------------------
    always_comb begin
        // Shift-add: add the multiplicand when the current multiplier bit is
        // set; the carry becomes the new top bit after the right shift.
        mul_sum   = {1'b0, acc[ACC_W-1:DATA_W]} + {1'b0, (acc[0] ? mag_b : '0)};
        // Restoring divide: shift the next dividend bit into the remainder and
        // try to subtract the divisor. When the trial succeeds the result is
        // below the divisor, so the low DATA_W bits hold it exactly.
        div_shift = acc[ACC_W-1:DATA_W-1];
        div_ge    = (div_shift >= {1'b0, mag_b});
        div_sub   = div_shift[DATA_W-1:0] - mag_b;
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
`ifdef DIV_ZERO_TRAP_EN
        div_zero  = (state == DONE) && dz_q;
`else
        div_zero  = 1'b0;
`endif
        case (state)
            IDLE: if (start) state_nxt = op ? DIV : MULT;
            MULT: if (cnt == LAST_STEP) state_nxt = FIX;
            DIV: begin
`ifdef DIV_ZERO_TRAP_EN
                // A trapped divide leaves after a single cycle so that done
                // lands one cycle after the start edge; no steps or FIX run.
                if (dz_q) state_nxt = DONE;
                else if (cnt == LAST_STEP) state_nxt = FIX;
`else
                if (cnt == LAST_STEP) state_nxt = FIX;
`endif
            end
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control: iteration counter and divide-by-zero flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
`ifdef DIV_ZERO_TRAP_EN
            dz_q <= 1'b0;
`endif
        end else begin
            if (state == IDLE) begin
                cnt <= '0;
`ifdef DIV_ZERO_TRAP_EN
                if (start) dz_q <= op && (B == '0);
`endif
            end else if (state == MULT || state == DIV) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath: operand latch and per-cycle steps
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            acc    <= {{DATA_W{1'b0}}, (op ? abs_w(A) : abs_w(B))};
            mag_b  <= op ? abs_w(B) : abs_w(A);
            sign_a <= A[DATA_W-1];
            sign_b <= B[DATA_W-1];
            op_q   <= op;
        end else if (state == MULT) begin
            acc <= {mul_sum, acc[DATA_W-1:1]};
        end else if (state == DIV) begin
            acc <= div_ge ? {div_sub, acc[DATA_W-2:0], 1'b1}
                          : {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
        end
    end

    // -------------------------------------------------------------------------
    // Result registers: sign correction in FIX
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIX) begin
            if (!op_q) begin
                {hi, lo} <= neg_acc(acc, sign_a ^ sign_b);
            end else begin
                lo <= neg_w(acc[DATA_W-1:0], sign_a ^ sign_b);
                hi <= neg_w(acc[ACC_W-1:DATA_W], sign_a);
            end
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
module tb_mult_div_seq;

`ifdef DIV_ZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fails  = 0;
    logic [31:0] last_hi = '0;
    logic [31:0] last_lo = '0;

    mult_div_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit integers.
    task automatic model(input bit o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el,
                         output bit ez, output int elat);
        longint sa, sb, p, q, r;
        sa = $signed(a);
        sb = $signed(b);
        ez   = 1'b0;
        elat = 33;
        if (!o) begin
            p  = sa * sb;
            eh = p[63:32];
            el = p[31:0];
        end else if (sb == 0) begin
            if (TRAP) begin
                eh   = last_hi;
                el   = last_lo;
                ez   = 1'b1;
                elat = 1;
            end else begin
                // quotient magnitude all ones, negated if the dividend is negative;
                // remainder carries the dividend's value and sign
                el = sa < 0 ? 32'h0000_0001 : 32'hFFFF_FFFF;
                eh = a;
            end
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            el = q[31:0];
            eh = r[31:0];
        end
    endtask

    // Issue one operation and follow it to completion. When pulse is set,
    // extra start requests with other operands are raised at cycles 5 and 20.
    task automatic do_op(input bit o, input logic [31:0] a, input logic [31:0] b,
                         input bit pulse, input string tag);
        logic [31:0] eh, el;
        bit          ez, seen, dz_at_done;
        int          elat, lat, nbusy, ndz, ndone;
        model(o, a, b, eh, el, ez, elat);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; op = 1'($urandom); A = $urandom; B = $urandom;
        nbusy = busy ? 1 : 0;
        ndz = 0; ndone = 0; seen = 1'b0; lat = 0; dz_at_done = 1'b0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            start = pulse && (n == 5 || n == 20);
            @(posedge clk); #1;
            start = 1'b0;
            if (busy) nbusy++;
            if (div_zero) ndz++;
            if (done) begin
                seen       = 1'b1;
                lat        = n;
                ndone++;
                dz_at_done = div_zero;
            end
        end
        check({tag, ".done_seen"}, 64'(seen), 64'(1));
        check({tag, ".latency"}, 64'(lat), 64'(elat));
        check({tag, ".hi"}, 64'(hi), 64'(eh));
        check({tag, ".lo"}, 64'(lo), 64'(el));
        check({tag, ".div_zero"}, 64'(dz_at_done), 64'(ez));
        check({tag, ".dz_pulses"}, 64'(ndz), 64'(ez ? 1 : 0));
        check({tag, ".busy_cycles"}, 64'(nbusy), 64'(elat + 1));
        @(posedge clk); #1;
        check({tag, ".done_after"}, 64'(done), 64'(0));
        check({tag, ".busy_after"}, 64'(busy), 64'(0));
        check({tag, ".hi_hold"}, 64'(hi), 64'(eh));
        check({tag, ".lo_hold"}, 64'(lo), 64'(el));
        last_hi = eh;
        last_lo = el;
    endtask

    function automatic logic [31:0] pick(input bit allow_zero);
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h8000_0000;
            1: v = 32'h7FFF_FFFF;
            2: v = 32'hFFFF_FFFF;
            3: v = allow_zero ? 32'h0 : 32'h1;
            4: v = 32'($urandom_range(0, 15)) - 32'd8;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        reset = 1'b0; start = 1'b0; op = 1'b0; A = '0; B = '0;
        #1;
        check("reset.busy", 64'(busy), 64'(0));
        check("reset.done", 64'(done), 64'(0));
        check("reset.div_zero", 64'(div_zero), 64'(0));
        check("reset.hi", 64'(hi), 64'(0));
        check("reset.lo", 64'(lo), 64'(0));
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, "mul_7_m3");
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_min_m1");
        do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, "mul_min_min");
        do_op(1'b1, 32'h0000_2211, 32'h0000_0100, 1'b0, "div_prior");
        check("prior.hi", 64'(hi), 64'(32'h11));
        check("prior.lo", 64'(lo), 64'(32'h22));
        do_op(1'b1, 32'd5, 32'd0, 1'b0, "div_5_0");
        do_op(1'b1, 32'hFFFF_FF00, 32'd0, 1'b0, "div_neg_0");

        // start pulses during a running divide are ignored; the next op is
        // issued in the cycle right after done has gone away
        do_op(1'b1, 32'd1000, 32'hFFFF_FFF9, 1'b1, "div_ignore");
        do_op(1'b0, 32'd123, 32'd456, 1'b0, "mul_after_done");

        // asynchronous reset in the middle of a multiply
        start = 1'b1; op = 1'b0; A = 32'd99; B = 32'd77;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("midrst.busy", 64'(busy), 64'(0));
        check("midrst.done", 64'(done), 64'(0));
        check("midrst.div_zero", 64'(div_zero), 64'(0));
        check("midrst.hi", 64'(hi), 64'(0));
        check("midrst.lo", 64'(lo), 64'(0));
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) ndone++;
            if (n == 4) reset = 1'b1;
        end
        check("midrst.no_done", 64'(ndone), 64'(0));
        last_hi = '0;
        last_lo = '0;
        do_op(1'b0, 32'd3, 32'd4, 1'b0, "mul_3_4_after_rst");

        for (int i = 0; i < 20; i++) begin
            logic [31:0] ra, rb;
            bit ro;
            ro = 1'($urandom);
            ra = pick(1'b1);
            rb = pick(1'b1);
            do_op(ro, ra, rb, 1'b0, ro ? "rnd_div" : "rnd_mul");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
